// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word producer / serial consumer side, slave = the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             sout_valid;
    logic             frame_done;

    modport master (
        output load_valid, din,
        input  load_ready, sout, sout_valid, frame_done
    );

    modport slave (
        input  load_valid, din,
        output load_ready, sout, sout_valid, frame_done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, with optional even-parity bit (PARITY_EN).
// Latency: first bit on the cycle after the load edge; frame_done the cycle after the last bit.
// Backpressure: load_ready only in IDLE; load_valid at other times is dropped, not queued.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    piso_serializer_if.slave bus
);
`ifdef PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    // Holds only the bits not yet presented; the MSB goes straight to sout at load.
    logic [WIDTH-2:0] rest_q, rest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             next_bit;
`ifdef PARITY_EN
    logic             parity_q, parity_d;

    assign next_bit = (cnt_q == CNT_W'(WIDTH - 1)) ? parity_q : rest_q[WIDTH-2];
`else
    assign next_bit = rest_q[WIDTH-2];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rest_q       <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rest_q       <= rest_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
`ifdef PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        rest_d       = rest_q;
        cnt_d        = cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        frame_done_d = 1'b0;
`ifdef PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    state_d      = SHIFT;
                    rest_d       = bus.din[WIDTH-2:0];
                    cnt_d        = '0;
                    sout_d       = bus.din[WIDTH-1];
                    sout_valid_d = 1'b1;
`ifdef PARITY_EN
                    parity_d     = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end else begin
                    rest_d       = rest_q << 1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    sout_d       = next_bit;
                    sout_valid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
